// File: rtl/ssd_driver.sv
// rtl/ssd_driver.sv - 13-bit binary to 4-digit BCD converter with multiplexed 7-segment scan
// Optional leading-zero blanking when SSD_LEADING_ZERO_BLANK_EN is defined.
module ssd_driver #(
  parameter int REFRESH_BITS = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic [15:0] bcd,
  output logic        busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [REFRESH_BITS-1:0] REFRESH_ONE = 1;

  logic [1:0]              state;
  logic [12:0]             last_value;
  logic [12:0]             shift;
  logic [15:0]             work;
  logic [15:0]             work_adj;
  logic [3:0]              iter;
  logic [REFRESH_BITS-1:0] refresh;
  logic [1:0]              digit;
  logic [3:0]              nibble;
  logic [6:0]              font;
  logic                    blank;

  assign busy = (state != IDLE);

  // Double-dabble correction: bump every nibble >= 5 before the shift.
  always_comb begin
    work_adj = work;
    for (int i = 0; i < 4; i++) begin
      if (work[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_value <= '0;
      shift      <= '0;
      work       <= '0;
      iter       <= '0;
      bcd        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (value != last_value) begin
            last_value <= value;
            shift      <= value;
            work       <= '0;
            iter       <= '0;
            state      <= CONVERT;
          end
        end
        CONVERT: begin
          work  <= {work_adj[14:0], shift[12]};
          shift <= {shift[11:0], 1'b0};
          iter  <= iter + 4'd1;
          if (iter == 4'd12) state <= DONE;
        end
        DONE: begin
          bcd   <= work;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign digit  = refresh[REFRESH_BITS-1 -: 2];
  assign nibble = bcd[{digit, 2'b00} +: 4];

  always_comb begin
    case (nibble)
      4'd0:    font = 7'b1000000;
      4'd1:    font = 7'b1111001;
      4'd2:    font = 7'b0100100;
      4'd3:    font = 7'b0110000;
      4'd4:    font = 7'b0011001;
      4'd5:    font = 7'b0010010;
      4'd6:    font = 7'b0000010;
      4'd7:    font = 7'b1111000;
      4'd8:    font = 7'b0000000;
      4'd9:    font = 7'b0010000;
      default: font = 7'b1111111;
    endcase
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // A digit is blank only when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    case (digit)
      2'd3:    blank = (bcd[15:12] == 4'd0);
      2'd2:    blank = (bcd[15:8] == 8'd0);
      2'd1:    blank = (bcd[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh <= '0;
      anode   <= 4'b1111;
      seg     <= 7'b1111111;
    end else begin
      refresh <= refresh + REFRESH_ONE;
      anode   <= ~(4'b0001 << digit);
      seg     <= blank ? 7'b1111111 : font;
    end
  end

endmodule
